// File: rtl/spi_master_seq.sv
// spi_master_seq
//   Frame sequencer for the SPI slave/RAM wrapper. Accepts one command from a
//   parallel port and serialises it as: start cycle, 3 command bits, 8 data
//   bits (MSB first). RD_DATA frames then wait RD_LAT cycles and sample 8
//   MISO bits, returned on rd_data with a one-cycle rd_valid pulse.
//
// Parameters
//   GAP_CYCLES : cycles SS_n stays high after every frame (>= 1)
//   RD_LAT     : idle cycles between last MOSI bit and first MISO sample (>= 1)
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op, cmd_data    : 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA; byte
//   rd_data, rd_valid   : last received byte, one-cycle update strobe
//   busy                : high from accept until the end of the gap
//   SS_n, MOSI, MISO    : serial link to the slave
module spi_master_seq #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, START, CMD, DATA, TURN, RECV, GAP} state_t;

    localparam logic [3:0] TURN_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  op_r;
    logic [10:0] tx;      // {cmd bits, data byte}, shifted out from bit 10
    logic [7:0]  shift;

    assign cmd_ready = (state == IDLE);

    // Outputs are registered for the state being entered, so each state's
    // SS_n/MOSI values appear during that state's own cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= '0;
            tx       <= '0;
            shift    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r  <= cmd_op;
                        tx    <= {cmd_op[1], cmd_op[1], cmd_op[0], cmd_data};
                        SS_n  <= 1'b0;
                        MOSI  <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    MOSI  <= tx[10];
                    tx    <= {tx[9:0], 1'b0};
                    cnt   <= '0;
                    state <= CMD;
                end
                CMD: begin
                    MOSI <= tx[10];
                    tx   <= {tx[9:0], 1'b0};
                    if (cnt == 4'd2) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt == 4'd7) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (op_r == 2'b11) begin
                            state <= TURN;
                        end else begin
                            SS_n  <= 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        MOSI <= tx[10];
                        tx   <= {tx[9:0], 1'b0};
                        cnt  <= cnt + 4'd1;
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECV: begin
                    shift <= {shift[6:0], MISO};
                    if (cnt == 4'd7) begin
                        rd_data  <= {shift[6:0], MISO};
                        rd_valid <= 1'b1;
                        SS_n     <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq
//   Bench for spi_master_seq. Two instances share the command bus: dut_a with
//   default parameters and dut_b with RD_LAT=2, GAP_CYCLES=3; only the
//   selected one sees cmd_valid. Expected per-cycle SS_n/MOSI/busy/ready/
//   rd_valid/rd_data are computed from the frame rules, and RD_DATA replies
//   come from a behavioural RAM slave model.
module tb_spi_master_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic       miso = 1'b1;
    logic       sel = 1'b0;
    logic       noise = 1'b0;

    logic       rdy_a, rdv_a, busy_a, ss_a, mosi_a;
    logic       rdy_b, rdv_b, busy_b, ss_b, mosi_b;
    logic [7:0] rd_a, rd_b;
    logic       rdy_o, rdv_o, busy_o, ss_o, mosi_o;
    logic [7:0] rd_o;
    logic       val_a, val_b;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr, rd_addr;
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    assign val_a = cmd_valid && !sel;
    assign val_b = cmd_valid && sel;

    always_comb begin
        rdy_o  = sel ? rdy_b  : rdy_a;
        rdv_o  = sel ? rdv_b  : rdv_a;
        busy_o = sel ? busy_b : busy_a;
        ss_o   = sel ? ss_b   : ss_a;
        mosi_o = sel ? mosi_b : mosi_a;
        rd_o   = sel ? rd_b   : rd_a;
    end

    spi_master_seq dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(val_a), .cmd_ready(rdy_a),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_data(rd_a), .rd_valid(rdv_a),
        .busy(busy_a), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso)
    );

    spi_master_seq #(.GAP_CYCLES(3), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(val_b), .cmd_ready(rdy_b),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_data(rd_b), .rd_valid(rdv_b),
        .busy(busy_b), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One complete frame on the selected DUT, checked cycle by cycle.
    // Starts anywhere before the idle cycle's falling edge; returns at the
    // falling edge of the last gap cycle.
    task automatic do_frame(input logic s, input logic [1:0] op, input logic [7:0] data,
                            input logic [7:0] rx, input logic hold);
        int lat, gap, n;
        logic [10:0] tx;
        lat = s ? 2 : 1;
        gap = s ? 3 : 1;
        n   = (op == 2'b11) ? 20 + lat : 12;
        tx  = {op[1], op[1], op[0], data};
        @(negedge clk);
        sel = s;
        #0;
        check("idle_ready", rdy_o, 8'd1);
        check("idle_ss", ss_o, 8'd1);
        check("idle_busy", busy_o, 8'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        miso      = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (!hold) cmd_valid = 1'b0;
                cmd_op   = 2'($urandom);
                cmd_data = 8'($urandom);
            end
            check("frame_ss", ss_o, 8'd0);
            check("frame_mosi", mosi_o, (k >= 1 && k <= 11) ? 8'(tx[11 - k]) : 8'd0);
            check("frame_busy", busy_o, 8'd1);
            check("frame_ready", rdy_o, 8'd0);
            check("frame_rdv", rdv_o, 8'd0);
            if (k >= 12 + lat && k <= 19 + lat)
                miso = rx[19 + lat - k];
            else
                miso = noise ? 1'($urandom) : 1'b1;
        end
        if (op == 2'b11) exp_rd[s] = rx;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_ss", ss_o, 8'd1);
            check("gap_mosi", mosi_o, 8'd0);
            check("gap_busy", busy_o, 8'd1);
            check("gap_ready", rdy_o, 8'd0);
            check("gap_rdv", rdv_o, (g == 0 && op == 2'b11) ? 8'd1 : 8'd0);
            check("gap_rd_data", rd_o, exp_rd[s]);
            miso = noise ? 1'($urandom) : 1'b1;
        end
    endtask

    // RAM slave model: address registers and memory decide the RD_DATA reply.
    task automatic sys_frame(input logic s, input logic [1:0] op, input logic [7:0] data,
                             input logic hold);
        logic [7:0] rx;
        rx = 8'h00;
        case (op)
            2'b00: wr_addr = data;
            2'b01: mem[wr_addr] = data;
            2'b10: rd_addr = data;
            default: rx = mem[rd_addr];
        endcase
        do_frame(s, op, data, rx, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wr_addr = '0;
        rd_addr = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // Reset held with a pending command and random MISO
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            miso = 1'($urandom);
            check("rst_ss_a", ss_a, 8'd1);
            check("rst_mosi_a", mosi_a, 8'd0);
            check("rst_busy_a", busy_a, 8'd0);
            check("rst_rdv_a", rdv_a, 8'd0);
            check("rst_rd_a", rd_a, 8'h00);
            check("rst_ready_a", rdy_a, 8'd1);
            check("rst_ss_b", ss_b, 8'd1);
            check("rst_busy_b", busy_b, 8'd0);
        end
        cmd_valid = 1'b0;
        miso = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // WR_ADDR 0xA5
        sys_frame(1'b0, 2'b00, 8'hA5, 1'b0);

        // Back-to-back WR_DATA 0x3C then RD_ADDR 0x3C with cmd_valid held
        sys_frame(1'b0, 2'b01, 8'h3C, 1'b1);
        sys_frame(1'b0, 2'b10, 8'h3C, 1'b0);

        // System loop through the RAM model
        sys_frame(1'b0, 2'b00, 8'h10, 1'b0);
        sys_frame(1'b0, 2'b01, 8'h5A, 1'b0);
        sys_frame(1'b0, 2'b10, 8'h10, 1'b0);
        sys_frame(1'b0, 2'b11, 8'hFF, 1'b0);

        // Standalone reads, RD_LAT=1 and RD_LAT=2
        do_frame(1'b0, 2'b11, 8'h00, 8'hC3, 1'b0);
        do_frame(1'b1, 2'b11, 8'h00, 8'hC3, 1'b0);

        // Reset in cycle 6 of a RD_DATA frame
        @(negedge clk);
        sel = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_data = 8'h81;
        @(posedge clk);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("mid_ss_before", ss_a, 8'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_ss_async", ss_a, 8'd1);
        check("mid_busy_async", busy_a, 8'd0);
        check("mid_rdv_async", rdv_a, 8'd0);
        check("mid_rd_async", rd_a, 8'h00);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rdv_hold", rdv_a, 8'd0);
        end
        rst_n = 1'b1;
        sys_frame(1'b0, 2'b00, 8'h01, 1'b0);

        // Randomised frames on both instances
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sys_frame(1'($urandom), 2'($urandom), 8'($urandom),
                      (i == 39) ? 1'b0 : 1'($urandom));
        end
        noise = 1'b0;
        @(negedge clk);
        check("end_idle_a", busy_a, 8'd0);
        check("end_idle_b", busy_b, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_master_seq.md
# spi_master_seq

Frame sequencer that drives the SPI slave/RAM wrapper from a parallel command port. It accepts one byte-level command at a time and serialises it onto SS_n/MOSI in the slave's frame format: start cycle, 3-bit command, 8 data bits MSB first. For read-data commands it also samples 8 MISO bits and returns them as a parallel byte. It sits between a host/register bus and the spi_wrapper instance, which is the only slave on the link.

## Interface
- GAP_CYCLES, 1: cycles SS_n is held high after every frame; minimum 1.
- RD_LAT, 1: idle cycles between the last MOSI data bit and the first MISO sample on a RD_DATA frame; minimum 1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command transfers on a rising edge with cmd_valid && cmd_ready.
- cmd_op  in  2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- cmd_data  in  8  address, write data, or dummy byte (RD_DATA).
- rd_data  out  8  last byte received on MISO; held until the next RD_DATA completes.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  high from accept until the end of GAP.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

## Operation
- States: IDLE, START, CMD, DATA, TURN, RECV, GAP. One 4-bit bit/cycle counter; cmd_op and cmd_data are captured into registers on accept.
- Command bits are {op[1], op[1], op[0]}: WR_ADDR=000, WR_DATA=001, RD_ADDR=110, RD_DATA=111.
- IDLE: SS_n=1, MOSI=0. On accept, go to START.
- START (1 cycle): SS_n=0, MOSI=0.
- CMD (3 cycles): MOSI = command bits, MSB first.
- DATA (8 cycles): MOSI = captured byte bits 7..0.
  - After DATA, RD_DATA goes to TURN; all other ops go to GAP.
- TURN (RD_LAT cycles): SS_n=0, MOSI=0.
- RECV (8 cycles): SS_n=0, MOSI=0. At the rising edge ending each RECV cycle, shift = {shift[6:0], MISO}.
- GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0. On GAP entry from RECV, rd_data <= shift and rd_valid=1 for that cycle only.
- After GAP, go to IDLE.
- cmd_op and cmd_data changes after accept are ignored. cmd_valid while busy is ignored, with no queueing.
- Reset (async, any state): state=IDLE, SS_n=1, MOSI=0, busy=0, rd_valid=0, rd_data=0, shift=0, cmd_ready=1. A frame aborted by reset produces no rd_valid.

## Timing
- SS_n, MOSI, busy, rd_valid and rd_data are registered outputs. cmd_ready is decoded from state==IDLE.
- Accept edge → SS_n low in the following cycle; there is no dead cycle.
- SS_n low duration: 12 cycles for WR_ADDR/WR_DATA/RD_ADDR; 20+RD_LAT cycles for RD_DATA (21 at default).
- RD_DATA MISO samples are taken in frame cycles 12+RD_LAT .. 19+RD_LAT, counting START as cycle 0.
- rd_valid is asserted in the cycle after the last sample.
- With cmd_valid held high, SS_n is high exactly GAP_CYCLES+1 cycles between frames (GAP plus one IDLE cycle).
- busy spans 12+GAP_CYCLES cycles for write/addr frames and 20+RD_LAT+GAP_CYCLES cycles for read-data frames. The accept cycle itself is IDLE.

## Test plan
- **Reset:** hold rst_n=0 for 5 cycles with cmd_valid=1 and random MISO → SS_n=1, MOSI=0, busy=0, rd_valid=0, rd_data=0x00, cmd_ready=1, no frame started. Then assert rst_n=0 asynchronously between edges → SS_n=1 immediately.
- **WR_ADDR 0xA5:** SS_n low exactly 12 cycles; MOSI = 0,0,0,0,1,0,1,0,0,1,0,1; cmd_ready low 13 cycles; no rd_valid.
- **Back-to-back WR_DATA 0x3C then RD_ADDR 0x3C:** cmd_valid held high; command bits 001 then 110; data bits 00111100 in both frames; SS_n high exactly 2 cycles between frames.
- **System loop with spi_wrapper:** WR_ADDR 0x10, WR_DATA 0x5A, RD_ADDR 0x10, RD_DATA dummy 0xFF → RD_DATA frame has SS_n low 21 cycles, one rd_valid pulse, rd_data=0x5A; MISO/MOSI match the golden wrapper.
- **Standalone read:** drive MISO = bits of 0xC3 in RECV cycles, and drive 1 in all other cycles → rd_data=0xC3. Rerun with RD_LAT=2 → SS_n low 22 cycles, rd_data still 0xC3.
- **Reset mid-frame:** assert rst_n=0 in cycle 6 of a RD_DATA frame → SS_n=1 at once and no rd_valid. After release, WR_ADDR 0x01 completes normally in 12 SS_n-low cycles.
